// File: rtl/seq_divider.sv
// Sequential 8-by-4 restoring divider, one quotient bit per clock, MSB first.
// Define DIVZERO_DETECT_EN to short-circuit B == 0 with a flagged zero result.
//
//   state | meaning
//   IDLE  | waiting for start (also holds a pending divide-by-zero result)
//   RUN   | eight restoring steps, busy asserted
//   DONE  | one-cycle done pulse; start here chains the next division
module seq_divider (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] prod,
    input  logic [3:0] B,
    output logic       busy,
    output logic       done,
    output logic [7:0] quot,
    output logic [3:0] rem,
    output logic       div_zero
);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    state_t     state_q;
    logic [7:0] dvd_q;
    logic [3:0] div_q;
    logic [4:0] prem_q;
    logic [6:0] qacc_q;
    logic [2:0] cnt_q;
    logic       busy_q;
    logic       done_q;
    logic [7:0] quot_q;
    logic [3:0] rem_q;

    logic [5:0] shift_d;
    logic       ge_d;
    logic [4:0] prem_d;
    logic [7:0] qacc_d;

    assign shift_d = {prem_q, dvd_q[7]};
    assign ge_d    = (shift_d >= {2'b00, div_q});
    assign prem_d  = ge_d ? 5'(shift_d - {2'b00, div_q}) : 5'(shift_d);
    assign qacc_d  = {qacc_q, ge_d};

`ifdef DIVZERO_DETECT_EN
    logic dz_q;
    logic dz_pend_q;
    assign div_zero = dz_q;
`else
    assign div_zero = 1'b0;
`endif

    assign busy = busy_q;
    assign done = done_q;
    assign quot = quot_q;
    assign rem  = rem_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            dvd_q     <= 8'h00;
            div_q     <= 4'h0;
            prem_q    <= 5'h00;
            qacc_q    <= 7'h00;
            cnt_q     <= 3'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            quot_q    <= 8'h00;
            rem_q     <= 4'h0;
`ifdef DIVZERO_DETECT_EN
            dz_q      <= 1'b0;
            dz_pend_q <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    state_q <= IDLE;
`ifdef DIVZERO_DETECT_EN
                    // B == 0 completes one edge after the sampling edge without entering RUN
                    if (dz_pend_q) begin
                        dz_pend_q <= 1'b0;
                        state_q   <= DONE;
                        done_q    <= 1'b1;
                        quot_q    <= 8'h00;
                        rem_q     <= 4'h0;
                        dz_q      <= 1'b1;
                    end else if (start && (B == 4'd0)) begin
                        dz_pend_q <= 1'b1;
                    end else
`endif
                    if (start) begin
                        state_q <= RUN;
                        busy_q  <= 1'b1;
                        dvd_q   <= prod;
                        div_q   <= B;
                        prem_q  <= 5'h00;
                        qacc_q  <= 7'h00;
                        cnt_q   <= 3'd7;
                    end
                end
                RUN: begin
                    dvd_q  <= {dvd_q[6:0], 1'b0};
                    prem_q <= prem_d;
                    qacc_q <= qacc_d[6:0];
                    cnt_q  <= cnt_q - 3'd1;
                    if (cnt_q == 3'd0) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        quot_q  <= qacc_d;
                        rem_q   <= prem_d[3:0];
`ifdef DIVZERO_DETECT_EN
                        dz_q    <= 1'b0;
`endif
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: latency, results, start-ignore, reset abort,
// and an exhaustive A*B / B inverse sweep with back-to-back starts.
module tb_seq_divider;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] prod;
    logic [3:0] B;
    logic       busy;
    logic       done;
    logic [7:0] quot;
    logic [3:0] rem;
    logic       div_zero;

    int n_checks = 0;
    int n_pass   = 0;

    seq_divider dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .prod     (prod),
        .B        (B),
        .busy     (busy),
        .done     (done),
        .quot     (quot),
        .rem      (rem),
        .div_zero (div_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Counts negedges from the one following the sampling edge until done.
    task automatic wait_done(output int lat, output int bcnt);
        lat  = 0;
        bcnt = 0;
        while (!done && lat < 20) begin
            bcnt += int'(busy);
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_op(input string tag, input logic [7:0] p, input logic [3:0] b,
                          input logic [7:0] eq, input logic [3:0] er, input logic edz,
                          input int elat, input int ebusy);
        int lat, bc;
        prod  = p;
        B     = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        prod  = ~p;
        B     = b ^ 4'hF;
        wait_done(lat, bc);
        check({tag, "_done"}, int'(done), 1);
        check({tag, "_lat"}, lat, elat);
        check({tag, "_busy"}, bc, ebusy);
        check({tag, "_quot"}, int'(quot), int'(eq));
        check({tag, "_rem"}, int'(rem), int'(er));
        check({tag, "_dz"}, int'(div_zero), int'(edz));
        @(negedge clk);
        check({tag, "_pulse"}, int'(done), 0);
        check({tag, "_hold"}, int'(quot), int'(eq));
    endtask

    initial begin
        int lat, bc, ndone, idx, dq, dr;
        rst_n = 1'b0;
        start = 1'b0;
        prod  = 8'h00;
        B     = 4'h0;
        repeat (2) @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_quot", int'(quot), 0);
        check("rst_rem", int'(rem), 0);
        check("rst_dz", int'(div_zero), 0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op("d69_7", 8'h69, 4'h7, 8'h0F, 4'h0, 1'b0, 8, 8);
        run_op("dC8_9", 8'hC8, 4'h9, 8'h16, 4'h2, 1'b0, 8, 8);
        run_op("dFF_1", 8'hFF, 4'h1, 8'hFF, 4'h0, 1'b0, 8, 8);
        run_op("dFF_F", 8'hFF, 4'hF, 8'h11, 4'h0, 1'b0, 8, 8);
        run_op("d00_5", 8'h00, 4'h5, 8'h00, 4'h0, 1'b0, 8, 8);
        run_op("dFE_D", 8'hFE, 4'hD, 8'h13, 4'h7, 1'b0, 8, 8);
`ifdef DIVZERO_DETECT_EN
        run_op("d55_0", 8'h55, 4'h0, 8'h00, 4'h0, 1'b1, 1, 0);
`else
        run_op("d55_0", 8'h55, 4'h0, 8'hFF, 4'h5, 1'b0, 8, 8);
`endif
        run_op("d69_7b", 8'h69, 4'h7, 8'h0F, 4'h0, 1'b0, 8, 8);

        // start re-pulsed mid-RUN with new operands must be ignored
        prod = 8'h69; B = 4'h7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        prod = 8'hC8; B = 4'h9; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ndone = 0; idx = -1; dq = -1; dr = -1;
        for (int i = 4; i < 30; i++) begin
            if (done) begin
                ndone++;
                if (idx < 0) begin idx = i; dq = int'(quot); dr = int'(rem); end
            end
            @(negedge clk);
        end
        check("ign_ndone", ndone, 1);
        check("ign_lat", idx, 8);
        check("ign_quot", dq, 8'h0F);
        check("ign_rem", dr, 0);

        // reset during RUN abandons the division
        prod = 8'hC8; B = 4'h9; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("rr_pre_busy", int'(busy), 1);
        check("rr_pre_quot", int'(quot), 8'h0F);
        rst_n = 1'b0;
        #1;
        check("rr_busy", int'(busy), 0);
        check("rr_done", int'(done), 0);
        check("rr_quot", int'(quot), 0);
        check("rr_rem", int'(rem), 0);
        check("rr_dz", int'(div_zero), 0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0; bc = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            ndone += int'(done);
            bc    += int'(busy);
        end
        check("rr_nodone", ndone, 0);
        check("rr_nobusy", bc, 0);
        run_op("rr_after", 8'hC8, 4'h9, 8'h16, 4'h2, 1'b0, 8, 8);

        // exhaustive inverse with start held high through DONE
        start = 1'b1;
        for (int a = 0; a < 16; a++) begin
            for (int bb = 1; bb < 16; bb++) begin
                prod = 8'(a * bb);
                B    = 4'(bb);
                @(negedge clk);
                wait_done(lat, bc);
                check($sformatf("inv_q_%0d_%0d", a, bb), int'(quot), a);
                check($sformatf("inv_r_%0d_%0d", a, bb), int'(rem), 0);
                check($sformatf("inv_lat_%0d_%0d", a, bb), lat, 8);
            end
        end
        start = 1'b0;
        @(negedge clk);
        check("inv_end_done", int'(done), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; ports named clk and rst_n.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 start  input  1  request to begin a division; sampled on the rising edge of clk.
REQ-005 prod  input  8  unsigned dividend; width matches the 4x4 multiplier product.
REQ-006 B  input  4  unsigned divisor.
REQ-007 busy  output  1  high while a division is iterating.
REQ-008 done  output  1  single-cycle pulse; quot/rem/div_zero valid from this cycle.
REQ-009 quot  output  8  unsigned quotient.
REQ-010 rem  output  4  unsigned remainder.
REQ-011 div_zero  output  1  divide-by-zero flag for the last completed operation.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-013 In IDLE or DONE, start=1 SHALL latch prod and B into internal registers, clear the partial remainder (5 bits) and step counter, and enter RUN.
REQ-014 In RUN, each cycle SHALL perform one restoring step: shift the next dividend bit, MSB first, into the partial remainder; if partial remainder >= B, subtract B and shift in quotient bit 1; otherwise shift in 0.
REQ-015 RUN SHALL last exactly 8 cycles, then enter DONE; busy=1 only in RUN.
REQ-016 Entering DONE SHALL load quot and rem; done=1 for exactly the one DONE cycle, which begins at the 8th rising edge after the edge that sampled start.
REQ-017 DONE SHALL return to IDLE on the next edge unless start=1, which begins a new operation (back-to-back, no idle gap).
REQ-018 start while in RUN SHALL be ignored; operand changes on prod/B during RUN SHALL NOT affect the result.
REQ-019 quot, rem and div_zero SHALL hold their values from DONE until the next DONE entry.
REQ-020 For B != 0, results SHALL satisfy prod = quot*B + rem with rem < B.

Reset
REQ-021 rst_n=0 SHALL immediately force state IDLE and busy=0, done=0, quot=0x00, rem=0x0, div_zero=0, and clear internal registers.
REQ-022 Reset asserted during RUN SHALL abandon the operation; no done pulse SHALL follow reset release without a new start.

Configuration
REQ-023 Macro DIVZERO_DETECT_EN SHALL select divide-by-zero handling.
REQ-024 With DIVZERO_DETECT_EN defined: start with B=0 SHALL go IDLE/DONE -> DONE directly (skip RUN, busy stays 0), set quot=0x00, rem=0x0, div_zero=1, done on the first edge after the start-sampling edge; any nonzero-divisor completion SHALL clear div_zero.
REQ-025 Without DIVZERO_DETECT_EN: div_zero SHALL be tied 0; B=0 SHALL run the normal 8-cycle algorithm, yielding quot=0xFF and rem=prod[3:0].

Verification
REQ-026 prod=0x69, B=0x7, start pulse -> busy high 8 cycles, done at 8th edge, quot=0x0F, rem=0x0.
REQ-027 prod=0xC8, B=0x9 -> quot=0x16, rem=0x2; prod=0xFF, B=0x1 -> quot=0xFF, rem=0x0.
REQ-028 Exhaustive inverse check: for all A in 0..15, B in 1..15, prod=A*B -> quot=A, rem=0 (240 operations, back-to-back starts held high through DONE).
REQ-029 prod=0x55, B=0x0 -> with DIVZERO_DETECT_EN: done 1 edge later, quot=0x00, rem=0x0, div_zero=1; without: done at 8th edge, quot=0xFF, rem=0x5, div_zero=0.
REQ-030 start re-pulsed at cycle 3 of RUN with different prod/B -> ignored; first result unchanged, exactly one done pulse.
REQ-031 rst_n pulled low at cycle 4 of RUN -> all outputs zero immediately; no done after release until a new start.
